// File: rtl/tgc_mode_ctrl_if.sv
// Purpose: bundles the mode sequencer's button, reload and lane-load inputs with its mode, tick and status outputs.
// Latency: none; this is wiring only.
// Backpressure: none; every signal is a plain level or a one-cycle pulse.
interface tgc_mode_ctrl_if;
  logic       mode_button;
  logic       reload_req;
  logic       load_strobe;
  logic [3:0] load_lane;
  logic [1:0] tgc_out;
  logic       slow_tick;
  logic [3:0] lanes_loaded;
  logic       press_pulse;
  logic       load_error;

  // Stimulus side: drives the requests and observes the mode outputs
  modport master (
    output mode_button, reload_req, load_strobe, load_lane,
    input  tgc_out, slow_tick, lanes_loaded, press_pulse, load_error
  );

  // Sequencer side
  modport slave (
    input  mode_button, reload_req, load_strobe, load_lane,
    output tgc_out, slow_tick, lanes_loaded, press_pulse, load_error
  );
endinterface

// File: rtl/tgc_mode_ctrl.sv
// Purpose: debounces the mode button, tracks loaded lanes and steps LOAD -> MODE_A <-> MODE_B; emits the run-mode slow tick.
// Latency: button rise to mode change is 3+DEBOUNCE_CYCLES cycles; reload_req takes effect on the sampling edge.
// Backpressure: none; all inputs are sampled every cycle and all outputs are pulses or levels.
module tgc_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SLOW_DIV        = 25_000_000
) (
  input logic            clock_fast,
  input logic            reset_n,
  tgc_mode_ctrl_if.slave bus
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int DIV_W = $clog2(SLOW_DIV);

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SLOW_DIV - 1);

  localparam logic [1:0] ST_LOAD = 2'b00;
  localparam logic [1:0] ST_A    = 2'b01;
  localparam logic [1:0] ST_B    = 2'b10;
  localparam logic [1:0] ST_ILL  = 2'b11;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [DB_W-1:0]  r_db_cnt;
  logic             r_press;
  logic [1:0]       r_state;
  logic [3:0]       r_mask;
  logic [DIV_W-1:0] r_div;

  logic       w_db_diff;
  logic       w_db_hit;
  logic       w_run;
  logic       w_all_loaded;
  logic [1:0] w_next;
  logic       w_load_error;
  logic       w_slow_tick;

  assign w_db_diff    = (r_sync2 != r_stable);
  assign w_db_hit     = w_db_diff && (r_db_cnt == DB_LAST);
  assign w_run        = (r_state == ST_A) || (r_state == ST_B);
  assign w_all_loaded = (r_mask == 4'hF);

  // Two-flop synchronizer for the raw asynchronous button
  always_ff @(posedge clock_fast or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= bus.mode_button;
      r_sync2 <= r_sync1;
    end
  end

  // Debouncer: accept a new level after DEBOUNCE_CYCLES consecutive differing samples; pulse on rising acceptance only
  always_ff @(posedge clock_fast or negedge reset_n) begin
    if (!reset_n) begin
      r_db_cnt <= '0;
      r_stable <= 1'b0;
      r_press  <= 1'b0;
    end else begin
      r_press <= w_db_hit && r_sync2;
      if (!w_db_diff || w_db_hit) begin
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
      if (w_db_hit) begin
        r_stable <= r_sync2;
      end
    end
  end

  // Mode state register
  always_ff @(posedge clock_fast or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_next;
    end
  end

  // Next mode: reload wins over a press; a press in LOAD only advances once every lane is loaded
  always_comb begin
    w_next = r_state;
    if (bus.reload_req) begin
      w_next = ST_LOAD;
    end else begin
      case (r_state)
        ST_LOAD: if (r_press && w_all_loaded) w_next = ST_A;
        ST_A:    if (r_press) w_next = ST_B;
        ST_B:    if (r_press) w_next = ST_A;
        default: w_next = ST_LOAD;
      endcase
    end
  end

  // Mode outputs: rejected press in LOAD and the divider terminal-count tick
  always_comb begin
    w_load_error = r_press && (r_state == ST_LOAD) && !w_all_loaded && !bus.reload_req;
    w_slow_tick  = w_run && (r_div == DIV_LAST);
  end

  // Sticky lane mask: accumulates strobes only while in LOAD, cleared by reload or illegal-state recovery
  always_ff @(posedge clock_fast or negedge reset_n) begin
    if (!reset_n) begin
      r_mask <= '0;
    end else if (bus.reload_req || (r_state == ST_ILL)) begin
      r_mask <= '0;
    end else if ((r_state == ST_LOAD) && bus.load_strobe) begin
      r_mask <= r_mask | bus.load_lane;
    end
  end

  // Slow divider: runs only in MODE_A/MODE_B and restarts from 0 on every mode change
  always_ff @(posedge clock_fast or negedge reset_n) begin
    if (!reset_n) begin
      r_div <= '0;
    end else if (!w_run || (w_next != r_state) || (r_div == DIV_LAST)) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  assign bus.tgc_out      = r_state;
  assign bus.lanes_loaded = r_mask;
  assign bus.press_pulse  = r_press;
  assign bus.load_error   = w_load_error;
  assign bus.slow_tick    = w_slow_tick;

endmodule

// File: tb/tb_tgc_mode_ctrl.sv
// Purpose: directed bench for tgc_mode_ctrl with a behavioural reference and hand-computed literal expectations.
// Latency: checks outputs on every falling edge against the reference.
// Backpressure: not applicable; stimulus is driven 2 time units after each rising edge.
module tb_tgc_mode_ctrl;
  localparam int DB  = 4;
  localparam int DIV = 8;

  logic clock_fast = 1'b0;
  logic reset_n;
  always #5 clock_fast = ~clock_fast;

  tgc_mode_ctrl_if bus ();

  tgc_mode_ctrl #(.DEBOUNCE_CYCLES(DB), .SLOW_DIV(DIV)) dut (
    .clock_fast(clock_fast),
    .reset_n   (reset_n),
    .bus       (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock_fast) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  // Mode 0 LOAD, 1 A, 2 B. A new debounced level is accepted when the last DB
  // synchronized samples (button values from 2..DB+1 edges ago) all disagree with it.
  int        m_mode;
  bit [3:0]  m_mask;
  bit        m_stable;
  bit        m_press;
  bit [15:0] m_hist;
  int        m_edges;
  int        m_entry;
  bit        m_prev_press;
  int        m_prev_mode;
  bit        m_all_diff;

  always @(posedge clock_fast or negedge reset_n) begin
    if (!reset_n) begin
      m_mode = 0; m_mask = 0; m_stable = 0; m_press = 0;
      m_hist = '0; m_edges = 0; m_entry = 0;
    end else begin
      m_edges++;
      m_prev_press = m_press;
      m_prev_mode  = m_mode;
      m_all_diff = 1'b1;
      for (int i = 1; i <= DB; i++) if (m_hist[i] == m_stable) m_all_diff = 1'b0;
      m_press = 1'b0;
      if (m_all_diff) begin
        m_stable = !m_stable;
        m_press  = m_stable;
      end
      if (bus.reload_req) begin
        m_mode = 0;
        m_mask = 0;
      end else begin
        if (m_prev_press) begin
          if (m_prev_mode == 0 && m_mask == 4'hF) m_mode = 1;
          else if (m_prev_mode == 1) m_mode = 2;
          else if (m_prev_mode == 2) m_mode = 1;
        end
        if (m_prev_mode == 0 && bus.load_strobe) m_mask = m_mask | bus.load_lane;
      end
      if (m_mode != m_prev_mode) m_entry = m_edges;
      m_hist = {m_hist[14:0], bus.mode_button};
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clock_fast) begin
    chk("tgc_out", bus.tgc_out, m_mode);
    chk("lanes_loaded", bus.lanes_loaded, m_mask);
    chk("press_pulse", bus.press_pulse, m_press);
    chk("load_error", bus.load_error,
        m_press && m_mode == 0 && m_mask != 4'hF && !bus.reload_req);
    chk("slow_tick", bus.slow_tick,
        m_mode != 0 && ((m_edges - m_entry + 1) % DIV) == 0);
  end

  // ---------------- event monitor ----------------
  int         n_press = 0;
  int         n_lerr  = 0;
  int         n_tick  = 0;
  logic [1:0] last_tgc = 2'b00;
  int         chg_cyc = 0;
  int         tick_off[$];
  logic [1:0] tgc_seq[$];

  always @(negedge clock_fast) begin
    if (bus.press_pulse === 1'b1) n_press++;
    if (bus.load_error === 1'b1) n_lerr++;
    if (bus.tgc_out !== last_tgc) begin
      tgc_seq.push_back(bus.tgc_out);
      chg_cyc = cyc;
      tick_off.delete();
    end
    if (bus.slow_tick === 1'b1) begin
      n_tick++;
      tick_off.push_back(cyc - chg_cyc + 1);
    end
    last_tgc = bus.tgc_out;
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clock_fast);
    #2;
  endtask

  task automatic press();
    bus.mode_button = 1'b1;
    step(DB + 6);
    bus.mode_button = 1'b0;
    step(DB + 6);
  endtask

  task automatic strobe(input logic [3:0] lanes);
    bus.load_strobe = 1'b1;
    bus.load_lane   = lanes;
    step(1);
    bus.load_strobe = 1'b0;
    bus.load_lane   = 4'h0;
    step(1);
  endtask

  int p0, e0, t0, s0, k, rise_cyc, lat;
  bit chatter[13];

  initial begin
    bus.mode_button = 1'b0;
    bus.reload_req  = 1'b0;
    bus.load_strobe = 1'b0;
    bus.load_lane   = 4'h0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    step(3);
    chk("rst_tgc", bus.tgc_out, 2'b00);
    chk("rst_mask", bus.lanes_loaded, 4'h0);
    chk("rst_tick", bus.slow_tick, 1'b0);
    chk("rst_press", bus.press_pulse, 1'b0);
    chk("rst_lerr", bus.load_error, 1'b0);
    reset_n = 1'b1;
    step(2);

    // Press with no lanes loaded: rejected
    e0 = n_lerr; p0 = n_press; t0 = n_tick;
    press();
    chk("lerr_count", n_lerr - e0, 1);
    chk("press_count_load", n_press - p0, 1);
    chk("tgc_after_reject", bus.tgc_out, 2'b00);

    // Load all four lanes one at a time, then press into MODE_A
    for (int i = 0; i < 4; i++) strobe(4'(1 << i));
    chk("mask_full", bus.lanes_loaded, 4'hF);
    chk("no_tick_in_load", n_tick - t0, 0);
    bus.mode_button = 1'b1;
    rise_cyc = cyc;
    step(DB + 6);
    bus.mode_button = 1'b0;
    step(DB + 6);
    chk("tgc_mode_a", bus.tgc_out, 2'b01);
    lat = chg_cyc - rise_cyc;
    chk("press_to_mode_latency_7pm1", (lat >= 6 && lat <= 8), 1'b1);

    // Three presses in MODE_A: B, A, B
    p0 = n_press; s0 = tgc_seq.size();
    press(); press(); press();
    chk("press_count_3", n_press - p0, 3);
    chk("tgc_changes_3", tgc_seq.size() - s0, 3);
    if (tgc_seq.size() >= s0 + 3) begin
      chk("tgc_seq0", tgc_seq[s0],     2'b10);
      chk("tgc_seq1", tgc_seq[s0 + 1], 2'b01);
      chk("tgc_seq2", tgc_seq[s0 + 2], 2'b10);
    end

    // Slow ticks relative to entry into MODE_B
    step(30);
    k = 0;
    foreach (tick_off[i]) begin
      if (tick_off[i] <= 40) begin
        chk("tick_offset", tick_off[i], 8 * (k + 1));
        k++;
      end
    end
    chk("tick_count_40", k, 5);

    // Chatter: glitches of 1..3 cycles, then release
    chatter = '{1, 0, 0, 1, 1, 0, 1, 1, 1, 0, 1, 1, 0};
    p0 = n_press;
    foreach (chatter[i]) begin
      bus.mode_button = chatter[i];
      step(1);
    end
    bus.mode_button = 1'b0;
    step(DB + 8);
    chk("chatter_no_press", n_press - p0, 0);
    chk("chatter_tgc", bus.tgc_out, 2'b10);

    // Back to MODE_A, then reload coincident with a press
    press();
    chk("tgc_back_to_a", bus.tgc_out, 2'b01);
    bus.mode_button = 1'b1;
    step(DB + 2);
    chk("press_coincident", bus.press_pulse, 1'b1);
    bus.reload_req = 1'b1;
    step(1);
    bus.reload_req = 1'b0;
    chk("reload_tgc", bus.tgc_out, 2'b00);
    chk("reload_mask", bus.lanes_loaded, 4'h0);
    bus.mode_button = 1'b0;
    step(DB + 6);
    chk("reload_stays_load", bus.tgc_out, 2'b00);

    // Reload again to MODE_A with multi-hot strobes
    strobe(4'b0101);
    chk("mask_0101", bus.lanes_loaded, 4'b0101);
    strobe(4'b1010);
    press();
    chk("tgc_a_again", bus.tgc_out, 2'b01);

    // Asynchronous reset in the middle of the divider
    step(3);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_tgc", bus.tgc_out, 2'b00);
    chk("arst_mask", bus.lanes_loaded, 4'h0);
    chk("arst_tick", bus.slow_tick, 1'b0);
    chk("arst_press", bus.press_pulse, 1'b0);
    chk("arst_lerr", bus.load_error, 1'b0);
    step(2);
    reset_n = 1'b1;
    step(3);
    chk("post_rst_tgc", bus.tgc_out, 2'b00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/tgc_mode_ctrl.md
# tgc_mode_ctrl

Mode sequencer that sits directly upstream of the mode select mux and drives its 2-bit `tgc_out` mode code. It debounces the raw mode push-button, tracks which of the four lanes have had their initial capacity loaded, and steps through LOAD → Mode A → Mode B → Mode A …. It also produces the slow-domain tick used by the traffic-light stages while a run mode is active.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronized samples required to accept a button level change (≥2).
- `SLOW_DIV`, default 25_000_000: `clock_fast` cycles per `slow_tick` (≥2).

Ports:
- `clock_fast`  in  1  single system clock; all logic on its rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `mode_button`  in  1  raw, asynchronous, bouncing push-button; active-high.
- `reload_req`  in  1  synchronous; forces return to LOAD.
- `load_strobe`  in  1  one-cycle pulse when a lane capacity is written.
- `load_lane`  in  4  one-hot (or multi-hot) lane mask qualifying `load_strobe`.
- `tgc_out`  out  2  mode code: 00 LOAD, 01 Mode A, 10 Mode B. 11 is never driven.
- `slow_tick`  out  1  one-cycle pulse every `SLOW_DIV` cycles while in Mode A or Mode B.
- `lanes_loaded`  out  4  sticky mask of lanes loaded since the last entry to LOAD.
- `press_pulse`  out  1  one-cycle pulse per debounced button press.
- `load_error`  out  1  one-cycle pulse when a press is rejected in LOAD.

## Operation
- Reset values: `tgc_out`=00, `lanes_loaded`=0000, `slow_tick`=0, `press_pulse`=0, `load_error`=0, debounce stable level=0, all counters=0.
- Button path:
  - 2-flop synchronizer feeds the debouncer.
  - The debounce counter increments each cycle the synchronized level differs from the stable level, and clears when they match.
  - When the count reaches `DEBOUNCE_CYCLES`, the stable level takes the synchronized value and the counter clears.
  - A 0→1 change of the stable level registers `press_pulse` high for exactly one cycle. Release produces no pulse.
- State machine, registered as `tgc_out`:
  - LOAD: a press with `lanes_loaded`==1111 moves to MODE_A. A press with any other mask stays in LOAD and pulses `load_error`.
  - MODE_A: a press moves to MODE_B.
  - MODE_B: a press moves to MODE_A.
  - `reload_req` high in any state moves to LOAD and clears `lanes_loaded` to 0000. `reload_req` beats a simultaneous `press_pulse`.
  - An illegal state (11) recovers to LOAD on the next edge, with the mask cleared.
- Load mask:
  - Only in LOAD and with `reload_req` low: on `load_strobe`, `lanes_loaded` |= `load_lane`.
  - Strobes in MODE_A or MODE_B are ignored.
  - The press qualification uses the registered mask. A strobe in the same cycle as a press does not count toward that press.
- Slow tick:
  - The divider counts 0..`SLOW_DIV`-1 only in MODE_A or MODE_B. It is held at 0 in LOAD.
  - The divider clears on every state change.
  - `slow_tick` is high when the counter equals `SLOW_DIV`-1; the counter then wraps to 0.

## Timing
- Raw button rise at edge 0, held clean: synchronized value is visible after edge 2. The stable level updates at edge 2+`DEBOUNCE_CYCLES`. `press_pulse` is high for the cycle after that edge.
- `tgc_out` changes on the edge that ends the `press_pulse` cycle. Button-to-mode latency is 3+`DEBOUNCE_CYCLES` cycles (±1 for synchronizer phase).
- A bounce shorter than `DEBOUNCE_CYCLES` cycles produces no pulse and no state change.
- `reload_req` sampled at edge N gives `tgc_out`=00 and `lanes_loaded`=0000 after edge N.
- First `slow_tick` after entering MODE_A or MODE_B is high `SLOW_DIV` cycles after the transition edge, then periodic with period `SLOW_DIV`.
- Assertion of `reset_n` mid-operation immediately forces all outputs to their reset values, independent of the clock. Deassertion is synchronous to `clock_fast`.

## Test plan
Benches use `DEBOUNCE_CYCLES`=4 and `SLOW_DIV`=8.
- Reset, then press with `lanes_loaded`=0000 → one `load_error` pulse; `tgc_out` stays 00.
- Strobe `load_lane` 0001, 0010, 0100, 1000, then press → `lanes_loaded`=1111; `tgc_out`=01 seven cycles after the button rise (±1).
- In MODE_A press three times → `tgc_out` sequence 10, 01, 10; exactly 3 `press_pulse` pulses.
- Button chatter of 1–3-cycle glitches followed by release → zero `press_pulse` pulses; `tgc_out` unchanged.
- In MODE_B for 40 cycles → `slow_tick` at cycles 8, 16, 24, 32, 40 after entry. In LOAD → no ticks.
- `reload_req` coincident with `press_pulse` in MODE_A → `tgc_out`=00, `lanes_loaded`=0000. Then `reset_n` low mid-divider → all outputs at reset values.
